// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
// One request outstanding at a time; inst_ack accepts in the same cycle, inst_rvalid is one cycle wide.
interface inst_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rvalid,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rvalid,
        output inst_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC owner, single-outstanding memory requester, IF/ID driver
// with a one-entry skid buffer, branch/exception redirect and misaligned-fetch (ADEF) detection.
module inst_fetch #(
    parameter logic [31:0]        RESET_PC   = 32'h1C000000,
    parameter int unsigned        ECODE_W    = 7,
    parameter logic [ECODE_W-1:0] ADEF_CAUSE = 7'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         pause,
    input  logic               branch_flush,
    input  logic [31:0]        branch_target,
    input  logic               exception_flush,
    input  logic [31:0]        exception_target,
    inst_fetch_if.master       mem,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_is_exception,
    output logic [ECODE_W-1:0] if_exception_cause,
    output logic               fetch_stall
);
    localparam int unsigned BW = 65 + ECODE_W;

    localparam logic [2:0] ST_REQ     = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_DISCARD = 3'd3;
    localparam logic [2:0] ST_EXC     = 3'd4;

    // Bundle layout: {pc, inst, is_exception, cause}
    localparam logic [BW-1:0] BUBBLE = {RESET_PC, 32'h0, 1'b0, {ECODE_W{1'b0}}};

    logic [2:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [BW-1:0] out_q, out_d;
    logic [BW-1:0] skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;

    logic          consume;
    logic          out_free;
    logic          misaligned;
    logic          flush;
    logic [31:0]   pc_inc;
    logic          unused_pause;

    assign unused_pause = ^{pause[5:2], pause[0]};

    assign consume    = out_valid_q & ~pause[1];
    assign out_free   = ~out_valid_q | consume;
    assign misaligned = pc_q[1:0] != 2'b00;
    assign flush      = branch_flush | exception_flush;
    assign pc_inc     = pc_q + 32'd4;

    // Gated by rst so no request is visible while reset is held.
    assign mem.inst_req  = rst & (state_q == ST_REQ) & ~misaligned;
    assign mem.inst_addr = pc_q;

    assign {if_pc, if_inst, if_is_exception, if_exception_cause} = out_q;
    assign fetch_stall = ~out_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        // Consume refills from skid first; fresh data below may override the bubble.
        if (consume) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_d       = BUBBLE;
                out_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_REQ: begin
                if (misaligned) begin
                    if (out_free) begin
                        out_d       = {pc_q, 32'h0, 1'b1, ADEF_CAUSE};
                        out_valid_d = 1'b1;
                    end else begin
                        skid_d       = {pc_q, 32'h0, 1'b1, ADEF_CAUSE};
                        skid_valid_d = 1'b1;
                    end
                    state_d = ST_EXC;
                end else if (mem.inst_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.inst_rvalid) begin
                    pc_d = pc_inc;
                    if (out_free) begin
                        out_d       = {pc_q, mem.inst_rdata, 1'b0, {ECODE_W{1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        skid_d       = {pc_q, mem.inst_rdata, 1'b0, {ECODE_W{1'b0}}};
                        skid_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (mem.inst_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_EXC: begin
                state_d = ST_EXC;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // A response still owed by memory must be dropped after a redirect.
        if (flush) begin
            pc_d         = exception_flush ? exception_target : branch_target;
            out_d        = BUBBLE;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if ((state_q == ST_WAIT) || (mem.inst_req && mem.inst_ack)) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            out_q        <= BUBBLE;
            out_valid_q  <= 1'b0;
            skid_q       <= BUBBLE;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a small memory model with configurable response latency
// and per-scenario tasks with hand-computed expected values.
module tb_inst_fetch;
    localparam logic [31:0] RPC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  pause = 6'd0;
    logic        branch_flush = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        exception_flush = 1'b0;
    logic [31:0] exception_target = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_is_exception;
    logic [6:0]  if_exception_cause;
    logic        fetch_stall;
    logic [71:0] bundle;
    logic [71:0] exp_b;

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .pause              (pause),
        .branch_flush       (branch_flush),
        .branch_target      (branch_target),
        .exception_flush    (exception_flush),
        .exception_target   (exception_target),
        .mem                (bus),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_is_exception    (if_is_exception),
        .if_exception_cause (if_exception_cause),
        .fetch_stall        (fetch_stall)
    );

    always #5 clk = ~clk;

    assign bus.inst_ack    = bus.inst_req;
    assign bus.inst_rvalid = mem_rvalid;
    assign bus.inst_rdata  = mem_rdata;
    assign bundle = {if_pc, if_inst, if_is_exception, if_exception_cause};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1C000000) return 32'h02800421;
        if (a == 32'h1C000004) return 32'h02800842;
        return ~a;
    endfunction

    // Response arrives mem_lat cycles after the accepting cycle.
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (pend_cnt == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(pend_addr);
        end
        if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (bus.inst_req && bus.inst_ack) begin
            pend_addr <= bus.inst_addr;
            if (mem_lat == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_word(bus.inst_addr);
                pend_cnt   <= 0;
            end else begin
                pend_cnt <= mem_lat - 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b0;
        pause = 6'd0;
        branch_flush = 1'b0;
        exception_flush = 1'b0;
        mem_lat = lat;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        do_reset(1);
        checks++;
        if (bus.inst_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", bus.inst_req);
        end
        checks++;
        if (bus.inst_addr !== RPC) begin
            errors++;
            $display("FAIL reset_addr: got %h expected %h", bus.inst_addr, RPC);
        end
        checks++;
        if (fetch_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 1", fetch_stall);
        end
        exp_b = {RPC, 32'h0, 1'b0, 7'h0};
        checks++;
        if (bundle !== exp_b) begin
            errors++;
            $display("FAIL reset_bundle: got %h expected %h", bundle, exp_b);
        end
    endtask

    task automatic test_straight_line();
        do_reset(1);
        rst = 1'b1;
        #1;  // cycle 1
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, RPC}) begin
            errors++;
            $display("FAIL first_req: got %b/%h expected 1/%h", bus.inst_req, bus.inst_addr, RPC);
        end
        cyc();  // cycle 2
        checks++;
        if ({bus.inst_req, fetch_stall} !== 2'b01) begin
            errors++;
            $display("FAIL wait_c2: got req=%b stall=%b expected req=0 stall=1",
                     bus.inst_req, fetch_stall);
        end
        cyc();  // cycle 3
        exp_b = {32'h1C000000, 32'h02800421, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall} !== {exp_b, 1'b0}) begin
            errors++;
            $display("FAIL straight_i0: got %h stall=%b expected %h stall=0",
                     bundle, fetch_stall, exp_b);
        end
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, 32'h1C000004}) begin
            errors++;
            $display("FAIL second_req: got %b/%h expected 1/1c000004", bus.inst_req, bus.inst_addr);
        end
        cyc();  // cycle 4
        exp_b = {RPC, 32'h0, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall} !== {exp_b, 1'b1}) begin
            errors++;
            $display("FAIL straight_bubble: got %h stall=%b expected %h stall=1",
                     bundle, fetch_stall, exp_b);
        end
        cyc();  // cycle 5
        exp_b = {32'h1C000004, 32'h02800842, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall} !== {exp_b, 1'b0}) begin
            errors++;
            $display("FAIL straight_i1: got %h stall=%b expected %h stall=0",
                     bundle, fetch_stall, exp_b);
        end
    endtask

    task automatic test_pause_skid();
        do_reset(1);
        rst = 1'b1;
        cyc();
        cyc();  // cycle 3: first instruction valid
        pause = 6'b000010;
        exp_b = {32'h1C000000, 32'h02800421, 1'b0, 7'h0};
        for (int c = 4; c <= 6; c++) begin
            cyc();
            checks++;
            if ({bundle, fetch_stall, bus.inst_req} !== {exp_b, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold_c%0d: got %h stall=%b req=%b expected %h stall=0 req=0",
                         c, bundle, fetch_stall, bus.inst_req, exp_b);
            end
        end
        cyc();  // cycle 7: release
        pause = 6'd0;
        cyc();  // cycle 8
        exp_b = {32'h1C000004, 32'h02800842, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall} !== {exp_b, 1'b0}) begin
            errors++;
            $display("FAIL skid_release: got %h stall=%b expected %h stall=0",
                     bundle, fetch_stall, exp_b);
        end
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, 32'h1C000008}) begin
            errors++;
            $display("FAIL skid_next_req: got %b/%h expected 1/1c000008", bus.inst_req, bus.inst_addr);
        end
    endtask

    task automatic test_branch_mid_wait();
        do_reset(2);
        rst = 1'b1;
        cyc();  // cycle 2: WAIT
        branch_flush = 1'b1;
        branch_target = 32'h1C000100;
        cyc();  // cycle 3: DISCARD, stale response present
        branch_flush = 1'b0;
        exp_b = {RPC, 32'h0, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall, bus.inst_req} !== {exp_b, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL branch_bubble: got %h stall=%b req=%b expected %h stall=1 req=0",
                     bundle, fetch_stall, bus.inst_req, exp_b);
        end
        cyc();  // cycle 4
        checks++;
        if ({bus.inst_req, bus.inst_addr, fetch_stall} !== {1'b1, 32'h1C000100, 1'b1}) begin
            errors++;
            $display("FAIL branch_req: got %b/%h stall=%b expected 1/1c000100 stall=1",
                     bus.inst_req, bus.inst_addr, fetch_stall);
        end
        cyc();
        cyc();
        cyc();  // cycle 7
        exp_b = {32'h1C000100, 32'hE3FFFEFF, 1'b0, 7'h0};
        checks++;
        if (bundle !== exp_b) begin
            errors++;
            $display("FAIL branch_fetch: got %h expected %h", bundle, exp_b);
        end
    endtask

    task automatic test_simultaneous_flush();
        do_reset(1);
        rst = 1'b1;
        cyc();
        cyc();  // cycle 3: output valid, request to 1c000004 accepted this cycle
        pause = 6'b000010;
        branch_flush = 1'b1;
        branch_target = 32'h1C000200;
        exception_flush = 1'b1;
        exception_target = 32'h1C008000;
        cyc();  // cycle 4
        branch_flush = 1'b0;
        exception_flush = 1'b0;
        exp_b = {RPC, 32'h0, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall, bus.inst_req} !== {exp_b, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dual_flush_bubble: got %h stall=%b req=%b expected %h stall=1 req=0",
                     bundle, fetch_stall, bus.inst_req, exp_b);
        end
        pause = 6'd0;
        cyc();  // cycle 5
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, 32'h1C008000}) begin
            errors++;
            $display("FAIL dual_flush_req: got %b/%h expected 1/1c008000", bus.inst_req, bus.inst_addr);
        end
        cyc();
        cyc();  // cycle 7
        exp_b = {32'h1C008000, 32'hE3FF7FFF, 1'b0, 7'h0};
        checks++;
        if (bundle !== exp_b) begin
            errors++;
            $display("FAIL dual_flush_fetch: got %h expected %h", bundle, exp_b);
        end
    endtask

    task automatic test_misaligned();
        do_reset(1);
        rst = 1'b1;
        #1;  // cycle 1: request accepted, then redirected
        branch_flush = 1'b1;
        branch_target = 32'h1C000102;
        cyc();  // cycle 2: DISCARD
        branch_flush = 1'b0;
        checks++;
        if (bus.inst_req !== 1'b0) begin
            errors++;
            $display("FAIL misal_discard_req: got %b expected 0", bus.inst_req);
        end
        cyc();  // cycle 3: REQ with misaligned pc
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b0, 32'h1C000102}) begin
            errors++;
            $display("FAIL misal_no_req: got %b/%h expected 0/1c000102", bus.inst_req, bus.inst_addr);
        end
        cyc();  // cycle 4
        exp_b = {32'h1C000102, 32'h0, 1'b1, 7'h08};
        checks++;
        if ({bundle, fetch_stall, bus.inst_req} !== {exp_b, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misal_adef: got %h stall=%b req=%b expected %h stall=0 req=0",
                     bundle, fetch_stall, bus.inst_req, exp_b);
        end
        for (int c = 5; c <= 6; c++) begin
            cyc();
            checks++;
            if ({fetch_stall, bus.inst_req} !== 2'b10) begin
                errors++;
                $display("FAIL misal_exc_c%0d: got stall=%b req=%b expected stall=1 req=0",
                         c, fetch_stall, bus.inst_req);
            end
        end
        exception_flush = 1'b1;
        exception_target = 32'h1C008000;
        cyc();  // cycle 7
        exception_flush = 1'b0;
        checks++;
        if ({bus.inst_req, bus.inst_addr} !== {1'b1, 32'h1C008000}) begin
            errors++;
            $display("FAIL misal_resume: got %b/%h expected 1/1c008000", bus.inst_req, bus.inst_addr);
        end
    endtask

    task automatic test_reset_wait();
        do_reset(2);
        rst = 1'b1;
        cyc();  // cycle 2: WAIT
        rst = 1'b0;
        cyc();  // cycle 3: reset applied, late response present
        exp_b = {RPC, 32'h0, 1'b0, 7'h0};
        checks++;
        if ({bundle, fetch_stall, bus.inst_req, bus.inst_addr} !== {exp_b, 1'b1, 1'b0, RPC}) begin
            errors++;
            $display("FAIL rstwait_values: got %h stall=%b req=%b addr=%h expected %h stall=1 req=0 addr=%h",
                     bundle, fetch_stall, bus.inst_req, bus.inst_addr, exp_b, RPC);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.inst_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_req: got %b expected 1", bus.inst_req);
        end
        cyc();  // cycle 4
        checks++;
        if ({bundle, fetch_stall} !== {exp_b, 1'b1}) begin
            errors++;
            $display("FAIL rstwait_late: got %h stall=%b expected %h stall=1",
                     bundle, fetch_stall, exp_b);
        end
        cyc();
        cyc();  // cycle 6
        exp_b = {RPC, 32'h02800421, 1'b0, 7'h0};
        checks++;
        if (bundle !== exp_b) begin
            errors++;
            $display("FAIL rstwait_refetch: got %h expected %h", bundle, exp_b);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_straight_line();
        test_pause_skid();
        test_branch_mid_wait();
        test_simultaneous_flush();
        test_misaligned();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end: owns the program counter, issues one-at-a-time requests to instruction memory, and drives the IF-side inputs of the IF/ID pipeline register (`if_pc`, `if_inst`, `if_is_exception`, `if_exception_cause`). It follows the core's `pause[5:0]` stall vector, redirects on `branch_flush` and `exception_flush`, and raises the instruction-fetch address exception (ADEF) on misaligned PCs. A one-entry skid buffer absorbs a memory response that arrives while the IF/ID register is paused.

## Interface
- `RESET_PC`, default 32'h1C000000: PC after reset; also the bubble PC value.
- `ECODE_W`, default 7: exception cause width; must match the core's exception-cause width.
- `ADEF_CAUSE`, default 7'h08: cause code for a misaligned fetch.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `pause`  in  6  core stall vector; bit 1 set means IF/ID holds and does not sample.
- `branch_flush`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch redirect PC.
- `exception_flush`  in  1  redirect to `exception_target`; wins over `branch_flush`.
- `exception_target`  in  32  exception entry or return PC.
- `inst_req`  out  1  memory request valid.
- `inst_addr`  out  32  request address, equal to the PC.
- `inst_ack`  in  1  request accepted in the same cycle.
- `inst_rvalid`  in  1  response valid, one cycle wide.
- `inst_rdata`  in  32  response instruction.
- `if_pc`  out  32  PC to IF/ID.
- `if_inst`  out  32  instruction to IF/ID.
- `if_is_exception`  out  1  fetch exception flag.
- `if_exception_cause`  out  ECODE_W  fetch exception cause.
- `fetch_stall`  out  1  asserted when no valid output is available; goes to the pause controller.

## Operation
- **Registers:** `pc`; output bundle plus `out_valid`; skid entry plus `skid_valid`; state register.
- **States:**
  - REQ: `inst_req=1`, `inst_addr=pc`.
  - WAIT: one request outstanding.
  - HOLD: skid buffer full.
  - DISCARD: drop the next response.
  - EXC: halted after ADEF.
- **Consume:** occurs when `out_valid & ~pause[1]`. On consume, the output bundle loads skid data, fresh response data, or bubble values (`RESET_PC`, 0, 0, 0) with `out_valid=0`, in that order of preference.
- **REQ state:**
  - If `pc[1:0]!=0`, `inst_req` stays 0. The output (or skid, if the output is occupied and not being consumed) loads {pc, 0, 1, ADEF_CAUSE}. Next state is EXC.
  - Otherwise, on `inst_ack`, go to WAIT.
- **WAIT state**, on `inst_rvalid`:
  - If the output is free or being consumed, load {pc, inst_rdata, 0, 0}, set `pc<=pc+4`, and go to REQ.
  - Otherwise, write the skid entry, set `pc<=pc+4`, and go to HOLD.
- **HOLD state:** on consume, skid moves to the output, skid clears, next state is REQ.
- **EXC state:** stays until a flush. No requests issued.
- **DISCARD state:** on `inst_rvalid`, the data is dropped and the next state is REQ.
- **Flush** (either flush, any state, any `pause` value):
  - `pc<=target`; `out_valid` and `skid_valid` cleared; output set to bubble values.
  - Next state is DISCARD if in WAIT, or in REQ with `inst_ack` that cycle. Otherwise next state is REQ.
  - If both flushes are asserted, the exception target is used.
- **`fetch_stall = ~out_valid`:** derived from registered state only; no combinational path from `pause` or the flushes.
- **Address arithmetic:** `pc+4` is 32-bit and wraps modulo 2^32.

## Timing
- **Reset values** while `rst==0`:
  - `pc=RESET_PC`, state REQ, `out_valid=0`, `skid_valid=0`.
  - `if_pc=RESET_PC`, `if_inst=0`, `if_is_exception=0`, `if_exception_cause=0`.
  - `inst_req=0`, `inst_addr=RESET_PC`, `fetch_stall=1`.
- **First request:** `inst_req` asserts in the first cycle after `rst` returns high.
- **Latency:** request accepted in cycle T, `inst_rvalid` in T+k (k≥1), outputs valid from T+k+1, next request in T+k+1.
- **Throughput:** peak one instruction every 2 cycles.
- **Handshake:** `inst_req`/`inst_addr` stay stable until `inst_ack`. Never more than one request outstanding. `inst_rvalid` outside WAIT/DISCARD is ignored.
- **Hold:** outputs stay stable every cycle `pause[1]==1`, unless a flush occurs.
- **Flush timing:** a flush in cycle T gives bubble outputs at T+1 and a request to the target at T+1 (or after the discarded response).
- **Reset mid-WAIT:** the state returns to REQ. The in-flight response after reset is ignored, because state is REQ, not WAIT.

## Test plan
- **Reset and straight-line fetch:** release `rst`; memory acks immediately and returns `inst_rvalid` 1 cycle later, with data `0x0280_0421` at 0x1C000000 and `0x0280_0842` at 0x1C000004. Required: `inst_req` in cycle 1; `if_pc=0x1C000000`, `if_inst=0x02800421` in cycle 3; then 0x1C000004 in cycle 5; `fetch_stall` low only in the valid cycles.
- **Pause with skid:** hold `pause[1]=1` for 4 cycles while the second response returns. Required: the first instruction is held on the outputs; the second goes to the skid; no request is issued in HOLD; after release, 0x1C000004 appears on the outputs the next cycle.
- **Branch flush mid-WAIT:** `branch_flush=1` with `branch_target=0x1C000100` while waiting. Required: bubble outputs next cycle; the pending response is dropped; the next `inst_addr` is 0x1C000100.
- **Simultaneous flushes:** assert `branch_flush` (target 0x1C000200) and `exception_flush` (target 0x1C008000) in the same cycle. Required: the next `inst_addr` is 0x1C008000.
- **Misaligned target:** branch to 0x1C000102. Required: no `inst_req`; outputs {0x1C000102, 0, 1, 0x08}; block stays in EXC with `fetch_stall=1` after consume, until `exception_flush` to 0x1C008000 resumes fetch.
- **Reset during WAIT:** drive `rst=0` for 1 cycle with a request outstanding. Required: all outputs return to their reset values; the late `inst_rvalid` produces no output.
